mux_sel_sequencer: RTL and testbench

Parallel-to-serial front end that captures an 8-bit word over a valid/ready handshake and walks a 3-bit select counter through all eight positions. The counter drives an internal `mux_8_1`, which picks one bit of the captured word per beat. The output is a serial bitstream with valid/ready/last framing. It sits directly upstream of the 8:1 mux: it owns the mux data input (held word) and the mux select (counter), and it consumes the mux output.

---
 rtl/mux_seq_pkg.sv | 20 ++
 rtl/mux_8_1.sv | 12 +
 rtl/mux_sel_sequencer.sv | 76 +++++++
 tb/tb_mux_sel_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared state type, widths and select endpoints for mux_sel_sequencer
package mux_seq_pkg;

   localparam int SEL_W  = 3;
   localparam int DATA_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
      return msb_first ? SEL_W'(DATA_W - 1) : SEL_W'(0);
   endfunction

   function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
      return msb_first ? SEL_W'(0) : SEL_W'(DATA_W - 1);
   endfunction

endpackage

// File: rtl/mux_8_1.sv
// rtl/mux_8_1.sv - 8:1 single-bit multiplexer
module mux_8_1
   import mux_seq_pkg::*;
(
   input  logic [DATA_W-1:0] i,
   input  logic [SEL_W-1:0]  s,
   output logic              o
);

   assign o = i[s];

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - serialises a captured byte through mux_8_1 by walking its select
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_last,
   output logic [SEL_W-1:0]  sel,
   output logic              busy
);

   localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

   state_e              state_q;
   logic [DATA_W-1:0]   word_q;
   logic [SEL_W-1:0]    sel_q;
   logic [SEL_W-1:0]    sel_d;

   assign sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         sel_q   <= SEL_START;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  word_q  <= in_data;
                  sel_q   <= SEL_START;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (ser_ready) begin
                  // On the final beat a waiting word is taken immediately, so there is no bubble.
                  if (sel_q == SEL_END) begin
                     if (in_valid) begin
                        word_q <= in_data;
                        sel_q  <= SEL_START;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     sel_q <= sel_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ser_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign ser_last  = (state_q == SEND) && (sel_q == SEL_END);
   assign in_ready  = (state_q == IDLE) || (ser_last && ser_ready);
   assign sel       = sel_q;

   mux_8_1 u_mux (
      .i (word_q),
      .s (sel_q),
      .o (ser_out)
   );

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - scoreboard bench driving MSB-first and LSB-first instances in lockstep
module tb_mux_sel_sequencer;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       ser_ready;

   logic       m_in_ready, m_out, m_valid, m_last, m_busy;
   logic [2:0] m_sel;
   logic       l_in_ready, l_out, l_valid, l_last, l_busy;
   logic [2:0] l_sel;

   int nvec = 0;
   int nerr = 0;

   logic [4:0] q_m[$];
   logic [4:0] q_l[$];

   mux_sel_sequencer #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
      .ser_out(m_out), .ser_valid(m_valid), .ser_ready(ser_ready), .ser_last(m_last),
      .sel(m_sel), .busy(m_busy)
   );

   mux_sel_sequencer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
      .ser_out(l_out), .ser_valid(l_valid), .ser_ready(ser_ready), .ser_last(l_last),
      .sel(l_sel), .busy(l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected beat entry is {bit, last, sel}.
   task automatic push_word(input logic [7:0] w);
      for (int k = 0; k < 8; k++) begin
         q_m.push_back({w[7-k], (k == 7), 3'(7 - k)});
         q_l.push_back({w[k],   (k == 7), 3'(k)});
      end
   endtask

   always @(negedge clk) begin
      if (!rst && m_valid) begin
         if (q_m.size() == 0) check("msb_unexpected_beat", {3'b0, m_out, m_last, m_sel}, 8'hEE);
         else begin
            check("msb_beat", {3'b0, m_out, m_last, m_sel}, {3'b0, q_m[0]});
            if (ser_ready) void'(q_m.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && l_valid) begin
         if (q_l.size() == 0) check("lsb_unexpected_beat", {3'b0, l_out, l_last, l_sel}, 8'hEE);
         else begin
            check("lsb_beat", {3'b0, l_out, l_last, l_sel}, {3'b0, q_l[0]});
            if (ser_ready) void'(q_l.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] w, input bit bp);
      int acc = 0;
      int i = 0;
      in_data  = w;
      in_valid = 1'b1;
      push_word(w);
      #1 check("in_ready_idle", {7'b0, m_in_ready}, 8'h01);
      cycle();
      in_valid = 1'b0;
      in_data  = ~w;
      while (acc < 8 && i < 64) begin
         ser_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
         #1 check("busy_send", {6'b0, m_busy, l_busy}, 8'h03);
         cycle();
         acc += int'(ser_ready);
         i++;
      end
      if (acc < 8) check("send_timeout", 8'(acc), 8'd8);
      #1 check("idle_after_word", {6'b0, m_valid, l_valid}, 8'h00);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      ser_ready = 1'b0;
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      check("rst_in_ready", {6'b0, m_in_ready, l_in_ready}, 8'h03);
      check("rst_valid_busy", {4'b0, m_valid, l_valid, m_busy, l_busy}, 8'h00);
      check("rst_last_out", {4'b0, m_last, l_last, m_out, l_out}, 8'h00);
      check("rst_sel_msb", {5'b0, m_sel}, 8'd7);
      check("rst_sel_lsb", {5'b0, l_sel}, 8'd0);
      cycle();

      send(8'b0111_0110, 1'b0);
      cycle();
      send(8'hA5, 1'b1);
      cycle();

      in_data  = 8'hFF;
      in_valid = 1'b1;
      ser_ready = 1'b1;
      push_word(8'hFF);
      push_word(8'h00);
      #1 check("b2b_in_ready_first", {7'b0, m_in_ready}, 8'h01);
      cycle();
      in_data = 8'h00;
      for (int beat = 1; beat <= 16; beat++) begin
         if (beat == 9) in_valid = 1'b0;
         #1;
         check("b2b_in_ready", {6'b0, m_in_ready, l_in_ready},
               ((beat == 8) || (beat == 16)) ? 8'h03 : 8'h00);
         check("b2b_valid", {6'b0, m_valid, l_valid}, 8'h03);
         cycle();
      end
      #1 check("b2b_idle", {6'b0, m_valid, l_valid}, 8'h00);
      cycle();

      in_data  = 8'hC3;
      in_valid = 1'b1;
      push_word(8'hC3);
      cycle();
      in_valid  = 1'b0;
      ser_ready = 1'b1;
      repeat (3) cycle();
      rst = 1'b1;
      #1;
      check("midrst_in_ready", {6'b0, m_in_ready, l_in_ready}, 8'h03);
      check("midrst_valid_busy", {4'b0, m_valid, l_valid, m_busy, l_busy}, 8'h00);
      check("midrst_last_out", {4'b0, m_last, l_last, m_out, l_out}, 8'h00);
      check("midrst_sel", {2'b0, m_sel, l_sel}, 8'b0011_1000);
      q_m.delete();
      q_l.delete();
      cycle();
      rst = 1'b0;
      cycle();
      send(8'h81, 1'b0);

      repeat (3) cycle();
      check("msb_queue_drained", 8'(q_m.size()), 8'd0);
      check("lsb_queue_drained", 8'(q_l.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
